// File: rtl/conv3x3_window_gen_if.sv
// Stream bundle for the 3x3 window generator: raster pixels in, packed 3x3 windows out.
// The generator binds to "slave"; whatever feeds pixels and drains windows binds to "master".
interface conv3x3_window_gen_if #(
    parameter int DATA_W = 8
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_W-1:0]     in_pixel;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_W*9-1:0]   window_flat;
    logic                  out_last;

    modport master (
        output in_valid,
        output in_pixel,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  window_flat,
        input  out_last
    );

    modport slave (
        input  in_valid,
        input  in_pixel,
        input  out_ready,
        output in_ready,
        output out_valid,
        output window_flat,
        output out_last
    );
endinterface

// File: rtl/conv3x3_window_gen.sv
// Zero-padded 3x3 window generator (stride 1, "same") over a raster pixel stream.
// Pixels land in a rolling two-line store; each window is gathered from it into a 3x3 register.
module conv3x3_window_gen #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 16,
    parameter int IMG_H  = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    conv3x3_window_gen_if.slave bus
);
    localparam int DEPTH = 2 * IMG_W + 4;
    localparam int AW    = $clog2(DEPTH);
    localparam int RW    = $clog2(IMG_H);
    localparam int CLW   = $clog2(IMG_W);
    localparam int CW    = $clog2(IMG_W * IMG_H + 1);

    localparam logic [CW-1:0]  PIX_TOTAL = CW'(IMG_W * IMG_H);
    localparam logic [RW-1:0]  ROW_LAST  = RW'(IMG_H - 1);
    localparam logic [CLW-1:0] COL_LAST  = CLW'(IMG_W - 1);
    localparam logic [AW-1:0]  SLOT_LAST = AW'(DEPTH - 1);

    if (IMG_W < 2 || IMG_H < 2) begin : g_bad_size
        $error("conv3x3_window_gen: IMG_W and IMG_H must both be >= 2");
    end

    // Pixels that must have arrived before window (r,c) is complete; capped at the frame edge.
    function automatic logic [CW-1:0] need_f(input logic [RW-1:0] r, input logic [CLW-1:0] c);
        int rr;
        int cc;
        rr = (int'(r) + 1 > IMG_H - 1) ? IMG_H - 1 : int'(r) + 1;
        cc = (int'(c) + 1 > IMG_W - 1) ? IMG_W - 1 : int'(c) + 1;
        return CW'(rr * IMG_W + cc + 1);
    endfunction

    function automatic logic [AW-1:0] slot_inc(input logic [AW-1:0] s);
        return (s == SLOT_LAST) ? '0 : s + AW'(1);
    endfunction

    function automatic logic [AW-1:0] slot_off(input logic [AW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s < 0) begin
            s = s + DEPTH;
        end else if (s >= DEPTH) begin
            s = s - DEPTH;
        end
        return AW'(s);
    endfunction

    logic [CW-1:0]       acc_cnt, acc_nxt, acc_inc;
    logic [RW-1:0]       orow, orow_nxt, next_row, load_row;
    logic [CLW-1:0]      ocol, ocol_nxt, next_col, load_col;
    logic [AW-1:0]       ctr_slot, ctr_nxt, load_slot;
    logic [AW-1:0]       wr_slot, wr_nxt;
    logic                win_valid, valid_nxt;
    logic                win_last, last_nxt;
    logic [DATA_W*9-1:0] window, window_nxt, taps;
    logic                can_accept, in_fire, out_fire;
    logic                at_last, load_hit, load_last;
    logic [DATA_W-1:0]   line_mem [DEPTH];

    assign can_accept = (acc_cnt <= need_f(orow, ocol)) && (acc_cnt < PIX_TOTAL);
    assign in_fire    = bus.in_valid && can_accept;
    assign out_fire   = win_valid && bus.out_ready;
    assign acc_inc    = acc_cnt + CW'(in_fire);

    assign at_last   = (orow == ROW_LAST) && (ocol == COL_LAST);
    assign next_col  = (ocol == COL_LAST) ? '0 : ocol + CLW'(1);
    assign next_row  = (ocol == COL_LAST) ? orow + RW'(1) : orow;

    // On a handshake the window being gathered is the next raster position, else the pending one.
    assign load_row  = out_fire ? next_row : orow;
    assign load_col  = out_fire ? next_col : ocol;
    assign load_slot = out_fire ? slot_inc(ctr_slot) : ctr_slot;
    assign load_hit  = acc_inc >= need_f(load_row, load_col);
    assign load_last = (load_row == ROW_LAST) && (load_col == COL_LAST);

    always_comb begin
        taps = '0;
        for (int k = 0; k < 9; k++) begin
            int            tr;
            int            tc;
            logic [AW-1:0] a;
            tr = int'(load_row) + k / 3 - 1;
            tc = int'(load_col) + k % 3 - 1;
            a  = slot_off(load_slot, (k / 3 - 1) * IMG_W + (k % 3 - 1));
            if (tr >= 0 && tr < IMG_H && tc >= 0 && tc < IMG_W) begin
                // The pixel written this cycle is not in the store yet, so take it from the port.
                if (in_fire && a == wr_slot) begin
                    taps[k*DATA_W +: DATA_W] = bus.in_pixel;
                end else begin
                    taps[k*DATA_W +: DATA_W] = line_mem[a];
                end
            end
        end
    end

    always_comb begin
        acc_nxt    = acc_inc;
        orow_nxt   = orow;
        ocol_nxt   = ocol;
        ctr_nxt    = ctr_slot;
        wr_nxt     = in_fire ? slot_inc(wr_slot) : wr_slot;
        valid_nxt  = win_valid;
        last_nxt   = win_last;
        window_nxt = window;
        if (out_fire && at_last) begin
            acc_nxt   = '0;
            orow_nxt  = '0;
            ocol_nxt  = '0;
            ctr_nxt   = '0;
            wr_nxt    = '0;
            valid_nxt = 1'b0;
            last_nxt  = 1'b0;
        end else if (out_fire || !win_valid) begin
            if (out_fire) begin
                orow_nxt = next_row;
                ocol_nxt = next_col;
                ctr_nxt  = slot_inc(ctr_slot);
            end
            if (load_hit) begin
                valid_nxt  = 1'b1;
                last_nxt   = load_last;
                window_nxt = taps;
            end else begin
                valid_nxt = 1'b0;
                last_nxt  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_cnt   <= '0;
            orow      <= '0;
            ocol      <= '0;
            ctr_slot  <= '0;
            wr_slot   <= '0;
            win_valid <= 1'b0;
            win_last  <= 1'b0;
            window    <= '0;
        end else begin
            acc_cnt   <= acc_nxt;
            orow      <= orow_nxt;
            ocol      <= ocol_nxt;
            ctr_slot  <= ctr_nxt;
            wr_slot   <= wr_nxt;
            win_valid <= valid_nxt;
            win_last  <= last_nxt;
            window    <= window_nxt;
        end
    end

    // Store contents are deliberately unreset; the counters decide what is meaningful.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            line_mem[wr_slot] <= bus.in_pixel;
        end
    end

    assign bus.in_ready    = can_accept;
    assign bus.out_valid   = win_valid;
    assign bus.out_last    = win_last;
    assign bus.window_flat = window;
endmodule

// File: tb/tb_conv3x3_window_gen.sv
// Bench for conv3x3_window_gen on a 4x3 image: hand-derived window table plus a padded-neighbourhood model.
module tb_conv3x3_window_gen;
    localparam int DW   = 8;
    localparam int W    = 4;
    localparam int H    = 3;
    localparam int NPIX = W * H;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    conv3x3_window_gen_if #(.DATA_W(DW)) bus ();

    conv3x3_window_gen #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int          r;
        int          c;
        logic [71:0] win;
        bit          last;
    } vec_t;

    vec_t        vtab[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          pixq[$];
    int          ref_pix[$];
    logic [71:0] cap_win[$];
    bit          cap_last[$];
    int          n_acc = 0;
    int          first_valid_acc = -1;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [71:0] pack9(input int t0, t1, t2, t3, t4, t5, t6, t7, t8);
        int          t[9];
        logic [71:0] w;
        int          v;
        t = '{t0, t1, t2, t3, t4, t5, t6, t7, t8};
        w = '0;
        for (int k = 0; k < 9; k++) begin
            v = t[k];
            w[k*8 +: 8] = v[7:0];
        end
        return w;
    endfunction

    // Neighbourhood of (r,c) read straight from the frame, zero outside the image.
    function automatic logic [71:0] model_win(input int base, input int r, input int c);
        logic [71:0] w;
        int          v;
        int          rr;
        int          cc;
        w = '0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                rr = r + dr;
                cc = c + dc;
                v  = (rr >= 0 && rr < H && cc >= 0 && cc < W) ? ref_pix[base + rr * W + cc] : 0;
                w[((dr + 1) * 3 + (dc + 1)) * 8 +: 8] = v[7:0];
            end
        end
        return w;
    endfunction

    task automatic add_vec(input int r, input int c, input logic [71:0] w, input bit l);
        vec_t v;
        v.r = r;
        v.c = c;
        v.win = w;
        v.last = l;
        vtab.push_back(v);
    endtask

    task automatic cycle(input bit want_in, input bit want_out);
        int t;
        t = (pixq.size() > 0) ? pixq[0] : 0;
        bus.in_valid  = want_in && (pixq.size() > 0);
        bus.in_pixel  = t[7:0];
        bus.out_ready = want_out;
        @(negedge clk);
        if (bus.out_valid && first_valid_acc < 0) first_valid_acc = n_acc;
        if (bus.in_valid && bus.in_ready) begin
            void'(pixq.pop_front());
            n_acc++;
        end
        if (bus.out_valid && bus.out_ready) begin
            cap_win.push_back(bus.window_flat);
            cap_last.push_back(bus.out_last);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        pixq.delete();
        cap_win.delete();
        cap_last.delete();
        n_acc = 0;
        first_valid_acc = -1;
    endtask

    task automatic run_until(input int n_win, input int pin, input int pout, input int budget,
                             input string tag);
        int cyc;
        cyc = 0;
        while (cap_win.size() < n_win && cyc < budget) begin
            cycle($urandom_range(99) < pin, $urandom_range(99) < pout);
            cyc++;
        end
        check({tag, " window count"}, cap_win.size(), n_win);
    endtask

    task automatic check_frames(input int nfr, input string tag);
        int p;
        for (int i = 0; i < nfr * NPIX; i++) begin
            p = i % NPIX;
            if (i < cap_win.size()) begin
                check($sformatf("%s win %0d", tag, i), cap_win[i],
                      model_win((i / NPIX) * NPIX, p / W, p % W));
                check($sformatf("%s last %0d", tag, i), cap_last[i], p == NPIX - 1);
            end
        end
    endtask

    task automatic load_ramp(input int n);
        for (int i = 1; i <= n; i++) pixq.push_back(i);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          unstable;
        int          n_last;
        int          p;
        int          cyc;
        logic [71:0] w0;

        bus.in_valid = 1'b0;
        bus.in_pixel = '0;
        bus.out_ready = 1'b0;

        add_vec(0, 0, pack9(0, 0, 0, 0, 1, 2, 0, 5, 6), 1'b0);
        add_vec(1, 0, pack9(0, 1, 2, 0, 5, 6, 0, 9, 10), 1'b0);
        add_vec(1, 1, pack9(1, 2, 3, 5, 6, 7, 9, 10, 11), 1'b0);
        add_vec(2, 3, pack9(7, 8, 0, 11, 12, 0, 0, 0, 0), 1'b1);

        repeat (2) @(posedge clk);
        reset_dut();
        check("reset out_valid", bus.out_valid, 1'b0);
        check("reset out_last", bus.out_last, 1'b0);
        check("reset window_flat", bus.window_flat, '0);
        check("reset in_ready", bus.in_ready, 1'b1);

        // Continuous ramp frame.
        ref_pix.delete();
        for (int i = 1; i <= NPIX; i++) ref_pix.push_back(i);
        load_ramp(NPIX);
        run_until(NPIX, 100, 100, 200, "ramp");
        check("ramp first valid after pixels", first_valid_acc, 6);
        check("ramp in_ready after frame", bus.in_ready, 1'b1);
        check("ramp out_valid after frame", bus.out_valid, 1'b0);
        repeat (5) cycle(1'b1, 1'b1);
        check("ramp no extra windows", cap_win.size(), NPIX);
        check_frames(1, "ramp");
        for (int i = 0; i < vtab.size(); i++) begin
            p = vtab[i].r * W + vtab[i].c;
            if (p < cap_win.size()) begin
                check($sformatf("table win (%0d,%0d)", vtab[i].r, vtab[i].c), cap_win[p], vtab[i].win);
                check($sformatf("table last (%0d,%0d)", vtab[i].r, vtab[i].c), cap_last[p], vtab[i].last);
            end
        end

        // Downstream stall after the first window.
        reset_dut();
        load_ramp(NPIX);
        cyc = 0;
        while (!bus.out_valid && cyc < 50) begin
            cycle(1'b1, 1'b0);
            cyc++;
        end
        check("stall first window seen", bus.out_valid, 1'b1);
        unstable = 0;
        w0 = model_win(0, 0, 0);
        repeat (10) begin
            cycle(1'b1, 1'b0);
            if (bus.window_flat !== w0 || bus.out_last !== 1'b0) unstable++;
        end
        check("stall accepted pixels", n_acc, 7);
        check("stall in_ready low", bus.in_ready, 1'b0);
        check("stall window unstable cycles", unstable, 0);
        run_until(NPIX, 100, 100, 200, "stall");
        check("stall accepted total", n_acc, NPIX);
        check_frames(1, "stall");

        // Three back-to-back random frames with random backpressure on both sides.
        reset_dut();
        ref_pix.delete();
        for (int i = 0; i < 3 * NPIX; i++) begin
            p = (i % 11 == 3) ? -128 : (i % 13 == 5) ? 127 : int'($urandom_range(255)) - 128;
            ref_pix.push_back(p);
            pixq.push_back(p);
        end
        run_until(3 * NPIX, 50, 50, 3000, "random");
        check_frames(3, "random");
        n_last = 0;
        foreach (cap_last[i]) if (cap_last[i]) n_last++;
        check("random out_last count", n_last, 3);

        // Reset in the middle of a frame, then a clean ramp frame.
        reset_dut();
        load_ramp(5);
        cyc = 0;
        while (n_acc < 5 && cyc < 30) begin
            cycle(1'b1, 1'b1);
            cyc++;
        end
        check("midreset partial accepted", n_acc, 5);
        reset_dut();
        ref_pix.delete();
        for (int i = 1; i <= NPIX; i++) ref_pix.push_back(i);
        load_ramp(NPIX);
        run_until(NPIX, 100, 100, 200, "midreset");
        check("midreset first valid after pixels", first_valid_acc, 6);
        check_frames(1, "midreset");

        // Signed extremes pass through; padding stays zero.
        reset_dut();
        ref_pix.delete();
        for (int i = 0; i < NPIX; i++) begin
            p = (i % 2 == 0) ? -128 : 127;
            ref_pix.push_back(p);
            pixq.push_back(p);
        end
        run_until(NPIX, 100, 100, 200, "signed");
        check_frames(1, "signed");
        if (cap_win.size() > 0) begin
            w0 = cap_win[0];
            check("signed centre tap", w0[39:32], 8'h80);
            check("signed pad tap", w0[7:0], 8'h00);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
